tlb: RTL and testbench

TLB -- requirements
Module: tlb

---
 rtl/tlb.sv | 154 +++++++++++++++
 tb/tb_tlb.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/tlb.sv
// Fully-associative MIPS-style TLB: two combinational search ports, one
// write port and one combinational read port, all entries held in flops.
module tlb #(
    parameter int unsigned TLBNUM = 16,
    localparam int unsigned IW = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [18:0]   s0_vpn2,
    input  logic          s0_odd_page,
    input  logic [7:0]    s0_asid,
    output logic          s0_found,
    output logic [IW-1:0] s0_index,
    output logic [19:0]   s0_pfn,
    output logic [2:0]    s0_c,
    output logic          s0_d,
    output logic          s0_v,
    input  logic [18:0]   s1_vpn2,
    input  logic          s1_odd_page,
    input  logic [7:0]    s1_asid,
    output logic          s1_found,
    output logic [IW-1:0] s1_index,
    output logic [19:0]   s1_pfn,
    output logic [2:0]    s1_c,
    output logic          s1_d,
    output logic          s1_v,
    input  logic          we,
    input  logic [IW-1:0] w_index,
    input  logic [18:0]   w_vpn2,
    input  logic [7:0]    w_asid,
    input  logic          w_g,
    input  logic [19:0]   w_pfn0,
    input  logic [2:0]    w_c0,
    input  logic          w_d0,
    input  logic          w_v0,
    input  logic [19:0]   w_pfn1,
    input  logic [2:0]    w_c1,
    input  logic          w_d1,
    input  logic          w_v1,
    input  logic [IW-1:0] r_index,
    output logic [18:0]   r_vpn2,
    output logic [7:0]    r_asid,
    output logic          r_g,
    output logic [19:0]   r_pfn0,
    output logic [2:0]    r_c0,
    output logic          r_d0,
    output logic          r_v0,
    output logic [19:0]   r_pfn1,
    output logic [2:0]    r_c1,
    output logic          r_d1,
    output logic          r_v1
);

    typedef struct packed {
        logic        e;
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } entry_t;

    typedef struct packed {
        logic          found;
        logic [IW-1:0] index;
        logic [19:0]   pfn;
        logic [2:0]    c;
        logic          d;
        logic          v;
    } srch_t;

    entry_t entries_q [TLBNUM];
    entry_t entries_d [TLBNUM];
    srch_t  s0_res;
    srch_t  s1_res;

    always_comb begin
        for (int unsigned i = 0; i < TLBNUM; i++) begin
            entries_d[i] = entries_q[i];
        end
        if (we) begin
            entries_d[w_index] = '{e: 1'b1, vpn2: w_vpn2, asid: w_asid, g: w_g,
                                   pfn0: w_pfn0, c0: w_c0, d0: w_d0, v0: w_v0,
                                   pfn1: w_pfn1, c1: w_c1, d1: w_d1, v1: w_v1};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < TLBNUM; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < TLBNUM; i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

    // First match in ascending order wins, so the lowest index is reported.
    function automatic srch_t lookup(input logic [18:0] vpn2, input logic odd,
                                     input logic [7:0] asid);
        srch_t r;
        r = '0;
        for (int unsigned i = 0; i < TLBNUM; i++) begin
            if (!r.found && entries_q[i].e && entries_q[i].vpn2 == vpn2 &&
                (entries_q[i].g || entries_q[i].asid == asid)) begin
                r.found = 1'b1;
                r.index = IW'(i);
                if (odd) begin
                    r.pfn = entries_q[i].pfn1;
                    r.c   = entries_q[i].c1;
                    r.d   = entries_q[i].d1;
                    r.v   = entries_q[i].v1;
                end else begin
                    r.pfn = entries_q[i].pfn0;
                    r.c   = entries_q[i].c0;
                    r.d   = entries_q[i].d0;
                    r.v   = entries_q[i].v0;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        s0_res = lookup(s0_vpn2, s0_odd_page, s0_asid);
        s1_res = lookup(s1_vpn2, s1_odd_page, s1_asid);
    end

    assign {s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v} = s0_res;
    assign {s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v} = s1_res;

    always_comb begin
        r_vpn2 = entries_q[r_index].vpn2;
        r_asid = entries_q[r_index].asid;
        r_g    = entries_q[r_index].g;
        r_pfn0 = entries_q[r_index].pfn0;
        r_c0   = entries_q[r_index].c0;
        r_d0   = entries_q[r_index].d0;
        r_v0   = entries_q[r_index].v0;
        r_pfn1 = entries_q[r_index].pfn1;
        r_c1   = entries_q[r_index].c1;
        r_d1   = entries_q[r_index].d1;
        r_v1   = entries_q[r_index].v1;
    end

endmodule

// File: tb/tb_tlb.sv
// Scoreboard bench for tlb: stimulus queues expected responses, a negedge
// monitor pops and compares them against the live outputs.
module tb_tlb;

    logic        clk = 1'b0;
    logic        resetn;
    logic [18:0] s0_vpn2, s1_vpn2, w_vpn2, r_vpn2;
    logic        s0_odd_page, s1_odd_page;
    logic [7:0]  s0_asid, s1_asid, w_asid, r_asid;
    logic        s0_found, s1_found, s0_d, s1_d, s0_v, s1_v;
    logic [3:0]  s0_index, s1_index, w_index, r_index;
    logic [19:0] s0_pfn, s1_pfn, w_pfn0, w_pfn1, r_pfn0, r_pfn1;
    logic [2:0]  s0_c, s1_c, w_c0, w_c1, r_c0, r_c1;
    logic        we, w_g, w_d0, w_v0, w_d1, w_v1;
    logic        r_g, r_d0, r_v0, r_d1, r_v1;

    tlb #(.TLBNUM(16)) dut (
        .clk(clk), .resetn(resetn),
        .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_asid(s0_asid),
        .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn),
        .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
        .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
        .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn),
        .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
        .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
        .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
        .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
        .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
        .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
        .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        string       name;
        logic [77:0] exp;
    } item_t;

    item_t       sb[$];
    item_t       it;
    logic [77:0] act;
    int          checks = 0;
    int          passed = 0;

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            it = sb.pop_front();
            case (it.kind)
                0:       act = 78'({s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v});
                1:       act = 78'({s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v});
                default: act = {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0,
                                r_pfn1, r_c1, r_d1, r_v1};
            endcase
            checks++;
            if (act !== it.exp)
                $display("FAIL %s: got %h required %h", it.name, act, it.exp);
            else
                passed++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic wr(input logic [3:0] idx, input logic [18:0] vpn2, input logic [7:0] asid,
                      input logic g, input logic [19:0] pfn0, input logic [2:0] c0,
                      input logic d0, input logic v0, input logic [19:0] pfn1,
                      input logic [2:0] c1, input logic d1, input logic v1);
        we = 1'b1; w_index = idx; w_vpn2 = vpn2; w_asid = asid; w_g = g;
        w_pfn0 = pfn0; w_c0 = c0; w_d0 = d0; w_v0 = v0;
        w_pfn1 = pfn1; w_c1 = c1; w_d1 = d1; w_v1 = v1;
    endtask

    task automatic srch(input int port, input string nm, input logic [18:0] vpn2,
                        input logic odd, input logic [7:0] asid, input logic f,
                        input logic [3:0] idx, input logic [19:0] pfn,
                        input logic [2:0] c, input logic d, input logic v);
        item_t x;
        if (port == 0) begin
            s0_vpn2 = vpn2; s0_odd_page = odd; s0_asid = asid;
        end else begin
            s1_vpn2 = vpn2; s1_odd_page = odd; s1_asid = asid;
        end
        x.kind = port;
        x.name = nm;
        x.exp  = 78'({f, idx, pfn, c, d, v});
        sb.push_back(x);
    endtask

    task automatic rd(input string nm, input logic [3:0] idx, input logic [77:0] exp);
        item_t x;
        r_index = idx;
        x.kind = 2;
        x.name = nm;
        x.exp  = exp;
        sb.push_back(x);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; we = 1'b0; w_index = '0; w_vpn2 = '0; w_asid = '0; w_g = 1'b0;
        w_pfn0 = '0; w_c0 = '0; w_d0 = 1'b0; w_v0 = 1'b0;
        w_pfn1 = '0; w_c1 = '0; w_d1 = 1'b0; w_v1 = 1'b0;
        s0_vpn2 = '0; s0_odd_page = 1'b0; s0_asid = '0;
        s1_vpn2 = '0; s1_odd_page = 1'b0; s1_asid = '0; r_index = '0;
        #1;
        srch(1, "rst_s1_miss", 19'h0, 1'b0, 8'h0, 1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0);
        srch(0, "rst_s0_miss", 19'h0, 1'b1, 8'h0, 1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0);
        rd("rst_read0", 4'd0, 78'h0);
        tick();
        resetn = 1'b1;
        tick();

        wr(4'd3, 19'h00400, 8'd5, 1'b0, 20'h11111, 3'd0, 1'b0, 1'b1,
           20'h22222, 3'd0, 1'b1, 1'b1);
        tick();
        srch(1, "idx3_odd", 19'h00400, 1'b1, 8'd5, 1'b1, 4'd3, 20'h22222, 3'd0, 1'b1, 1'b1);
        srch(0, "idx3_asid_miss", 19'h00400, 1'b1, 8'd6, 1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0);
        rd("read3", 4'd3, {19'h00400, 8'd5, 1'b0, 20'h11111, 3'd0, 1'b0, 1'b1,
                           20'h22222, 3'd0, 1'b1, 1'b1});
        tick();
        srch(0, "idx3_even", 19'h00400, 1'b0, 8'd5, 1'b1, 4'd3, 20'h11111, 3'd0, 1'b0, 1'b1);

        wr(4'd7, 19'h00400, 8'h22, 1'b1, 20'h33333, 3'd3, 1'b1, 1'b1,
           20'h44444, 3'd2, 1'b0, 1'b1);
        tick();
        srch(1, "global_hit7", 19'h00400, 1'b0, 8'd9, 1'b1, 4'd7, 20'h33333, 3'd3, 1'b1, 1'b1);
        srch(0, "lowest_3_over_7", 19'h00400, 1'b1, 8'd5, 1'b1, 4'd3, 20'h22222, 3'd0, 1'b1, 1'b1);
        wr(4'd2, 19'h00400, 8'd9, 1'b0, 20'h55555, 3'd1, 1'b0, 1'b1,
           20'h66666, 3'd4, 1'b1, 1'b0);
        tick();
        srch(1, "lowest_2_over_7", 19'h00400, 1'b1, 8'd9, 1'b1, 4'd2, 20'h66666, 3'd4, 1'b1, 1'b0);
        srch(0, "asid22_only7", 19'h00400, 1'b0, 8'h22, 1'b1, 4'd7, 20'h33333, 3'd3, 1'b1, 1'b1);

        wr(4'd4, 19'h12345, 8'd1, 1'b0, 20'h0abcd, 3'd2, 1'b1, 1'b0,
           20'h77777, 3'd5, 1'b0, 1'b1);
        tick();
        srch(0, "invalid_even4", 19'h12345, 1'b0, 8'd1, 1'b1, 4'd4, 20'h0abcd, 3'd2, 1'b1, 1'b0);
        srch(1, "concurrent_odd4", 19'h12345, 1'b1, 8'd1, 1'b1, 4'd4, 20'h77777, 3'd5, 1'b0, 1'b1);
        tick();

        // Write and search/read of the same entry within one cycle.
        wr(4'd1, 19'h7ffff, 8'hff, 1'b0, 20'hfffff, 3'd7, 1'b1, 1'b1,
           20'h00001, 3'd1, 1'b0, 1'b1);
        srch(1, "same_cycle_miss", 19'h7ffff, 1'b0, 8'hff, 1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0);
        rd("same_cycle_read_old", 4'd1, 78'h0);
        tick();
        srch(1, "next_cycle_hit", 19'h7ffff, 1'b0, 8'hff, 1'b1, 4'd1, 20'hfffff, 3'd7, 1'b1, 1'b1);
        rd("next_cycle_read", 4'd1, {19'h7ffff, 8'hff, 1'b0, 20'hfffff, 3'd7, 1'b1, 1'b1,
                                     20'h00001, 3'd1, 1'b0, 1'b1});
        tick();

        // Reset pulse lands while a write to idx 5 is pending.
        wr(4'd5, 19'h00400, 8'd5, 1'b1, 20'h99999, 3'd1, 1'b1, 1'b1,
           20'h88888, 3'd1, 1'b1, 1'b1);
        #2;
        resetn = 1'b0;
        srch(1, "rst_mid_s1_miss", 19'h00400, 1'b0, 8'd5, 1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0);
        srch(0, "rst_mid_s0_miss", 19'h12345, 1'b1, 8'd1, 1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0);
        rd("rst_mid_read3", 4'd3, 78'h0);
        tick();
        resetn = 1'b1;
        wr(4'd6, 19'h00abc, 8'd3, 1'b0, 20'h13579, 3'd6, 1'b0, 1'b1,
           20'h2468a, 3'd2, 1'b1, 1'b0);
        tick();
        rd("write_discarded5", 4'd5, 78'h0);
        srch(1, "post_rst_write6", 19'h00abc, 1'b0, 8'd3, 1'b1, 4'd6, 20'h13579, 3'd6, 1'b0, 1'b1);
        srch(0, "post_rst_old7_miss", 19'h00400, 1'b0, 8'h22, 1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0);
        tick();
        rd("post_rst_read1", 4'd1, 78'h0);

        for (int n = 0; n < 20 && sb.size() > 0; n++) @(posedge clk);
        if (sb.size() > 0) begin
            checks++;
            $display("FAIL drain: got %0d pending required 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
